// File: rtl/pl_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pl_hazard_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF  = 32;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned CNT_W           = 6;
  localparam int unsigned STALL_W         = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  // Counter preload: latency minus one, since the start cycle itself is not counted.
  function automatic logic [CNT_W-1:0] md_load_val(input logic        is_div,
                                                   input int unsigned mult_c,
                                                   input int unsigned div_c);
    return is_div ? CNT_W'(div_c - 1) : CNT_W'(mult_c - 1);
  endfunction

endpackage

// File: rtl/pl_hazard_control_if.sv
// Pipeline-side signals of the hazard controller.
interface pl_hazard_control_if;
  import pl_hazard_pkg::*;

  logic [REG_W-1:0]   IF_ID_rs;
  logic [REG_W-1:0]   IF_ID_rt;
  logic               ID_uses_rt;
  logic               ID_reads_hilo;
  logic               ID_is_md;
  logic [REG_W-1:0]   ID_EX_rt;
  logic               ID_EX_mem_read;
  logic               EX_md_start;
  logic               EX_md_is_div;
  logic               EX_branch_taken;
  logic               pc_write;
  logic               IF_ID_write;
  logic               IF_ID_flush;
  logic               ID_EX_bubble;
  logic               md_busy;
  logic               md_done;
  logic [STALL_W-1:0] stall_cycles;

  modport master (
    output IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_reads_hilo, ID_is_md,
           ID_EX_rt, ID_EX_mem_read, EX_md_start, EX_md_is_div, EX_branch_taken,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
           md_busy, md_done, stall_cycles
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_reads_hilo, ID_is_md,
           ID_EX_rt, ID_EX_mem_read, EX_md_start, EX_md_is_div, EX_branch_taken,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
           md_busy, md_done, stall_cycles
  );

endinterface

// File: rtl/pl_md_counter.sv
// Multiply/divide latency counter: preload, count down while waiting, pulse done after zero.
module pl_md_counter
  import pl_hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             run_i,
  output logic             cnt_zero_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  assign cnt_zero_o = (cnt_q == '0);
  assign done_o     = done_q;

  // Next count and done pulse; done fires the cycle after the last wait cycle.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = run_i && cnt_zero_o;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (run_i && !cnt_zero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter and done registers; reset aborts any pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/pl_hazard_control.sv
// Pipeline hazard controller: load-use and HI/LO stalls, branch flush, mult/div tracking.
module pl_hazard_control
  import pl_hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  pl_hazard_control_if.slave  hz
);

  md_state_e          state_q, state_d;
  logic               md_load;
  logic               cnt_zero;
  logic               md_done;
  logic               load_use;
  logic               md_hazard;
  logic               stall;
  logic               pc_write_c;
  logic               if_id_write_c;
  logic               if_id_flush_c;
  logic               id_ex_bubble_c;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Hazard detection; the HI/LO hazard is masked during reset so reset never stalls on it.
  assign load_use  = hz.ID_EX_mem_read && (hz.ID_EX_rt != '0) &&
                     ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                      (hz.ID_uses_rt && (hz.ID_EX_rt == hz.IF_ID_rt)));
  assign md_hazard = (state_q == MD_WAIT) && !rst && (hz.ID_reads_hilo || hz.ID_is_md);
  assign stall     = (load_use || md_hazard) && !hz.EX_branch_taken;

  // Next state and zero-latency pipeline controls; a taken branch overrides any stall.
  always_comb begin
    state_d        = state_q;
    md_load        = 1'b0;
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.EX_md_start && !hz.EX_branch_taken) begin
          state_d = MD_WAIT;
          md_load = 1'b1;
        end
      end
      MD_WAIT: begin
        if (cnt_zero) begin
          state_d = RUN;
        end
      end
    endcase

    if (hz.EX_branch_taken) begin
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
    end else if (stall) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_bubble_c = 1'b1;
    end
  end

  // Saturating stall-cycle count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  // State and stall-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pl_md_counter u_md_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (md_load),
    .load_val_i (md_load_val(hz.EX_md_is_div, MULT_CYCLES, DIV_CYCLES)),
    .run_i      (state_q == MD_WAIT),
    .cnt_zero_o (cnt_zero),
    .done_o     (md_done)
  );

  assign hz.pc_write     = pc_write_c;
  assign hz.IF_ID_write  = if_id_write_c;
  assign hz.IF_ID_flush  = if_id_flush_c;
  assign hz.ID_EX_bubble = id_ex_bubble_c;
  assign hz.md_busy      = (state_q == MD_WAIT);
  assign hz.md_done      = md_done;
  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pl_hazard_control.sv
// Directed bench for pl_hazard_control: vector table plus multi-cycle sequences.
module tb_pl_hazard_control;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   exp_stalls;

  pl_hazard_control_if hz ();

  pl_hazard_control dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       reads_hilo;
    logic       ex_rt_valid_dummy;
    logic [4:0] ex_rt;
    logic       mem_read;
    logic       br;
    logic       e_pc;
    logic       e_ifid;
    logic       e_flush;
    logic       e_bub;
    logic       e_stall;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    hz.IF_ID_rs        = '0;
    hz.IF_ID_rt        = '0;
    hz.ID_uses_rt      = 1'b0;
    hz.ID_reads_hilo   = 1'b0;
    hz.ID_is_md        = 1'b0;
    hz.ID_EX_rt        = '0;
    hz.ID_EX_mem_read  = 1'b0;
    hz.EX_md_start     = 1'b0;
    hz.EX_md_is_div    = 1'b0;
    hz.EX_branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_stalls = 0;
  endtask

  task automatic chk_ctl(input string name, input logic pc, input logic ifid,
                         input logic fl, input logic bub);
    chk({name, ".pc_write"},     32'(hz.pc_write),     32'(pc));
    chk({name, ".IF_ID_write"},  32'(hz.IF_ID_write),  32'(ifid));
    chk({name, ".IF_ID_flush"},  32'(hz.IF_ID_flush),  32'(fl));
    chk({name, ".ID_EX_bubble"}, 32'(hz.ID_EX_bubble), 32'(bub));
  endtask

  initial begin
    bit seen_done;
    n_tests = 0;
    n_fail  = 0;
    exp_stalls = 0;

    //           name          rs rt ur hl dm exrt mr br  pc ifid fl bub stall
    vecs[0] = '{"no_hazard",   1, 2, 1, 0, 0, 3,  1, 0,  1, 1,  0, 0,  0};
    vecs[1] = '{"lu_rs",       5, 7, 1, 0, 0, 5,  1, 0,  0, 0,  0, 1,  1};
    vecs[2] = '{"lu_rt",       6, 5, 1, 0, 0, 5,  1, 0,  0, 0,  0, 1,  1};
    vecs[3] = '{"rt_unused",   6, 5, 0, 0, 0, 5,  1, 0,  1, 1,  0, 0,  0};
    vecs[4] = '{"zero_reg",    0, 0, 1, 0, 0, 0,  1, 0,  1, 1,  0, 0,  0};
    vecs[5] = '{"not_load",    5, 5, 1, 0, 0, 5,  0, 0,  1, 1,  0, 0,  0};
    vecs[6] = '{"br_over_lu",  5, 7, 1, 0, 0, 5,  1, 1,  1, 1,  1, 1,  0};
    vecs[7] = '{"br_only",     1, 2, 1, 0, 0, 3,  0, 1,  1, 1,  1, 1,  0};
    vecs[8] = '{"hilo_in_run", 1, 2, 0, 1, 0, 3,  0, 0,  1, 1,  0, 0,  0};

    clear_in();
    do_reset();

    // Reset state
    chk("rst.md_busy",      32'(hz.md_busy),      32'd0);
    chk("rst.md_done",      32'(hz.md_done),      32'd0);
    chk("rst.stall_cycles", 32'(hz.stall_cycles), 32'd0);
    chk_ctl("rst", 1'b1, 1'b1, 1'b0, 1'b0);

    // Combinational vector table, stall counter tracked by the model
    for (int i = 0; i < 9; i++) begin
      clear_in();
      hz.IF_ID_rs        = vecs[i].rs;
      hz.IF_ID_rt        = vecs[i].rt;
      hz.ID_uses_rt      = vecs[i].uses_rt;
      hz.ID_reads_hilo   = vecs[i].reads_hilo;
      hz.ID_EX_rt        = vecs[i].ex_rt;
      hz.ID_EX_mem_read  = vecs[i].mem_read;
      hz.EX_branch_taken = vecs[i].br;
      #1;
      chk_ctl(vecs[i].name, vecs[i].e_pc, vecs[i].e_ifid, vecs[i].e_flush, vecs[i].e_bub);
      tick();
      if (vecs[i].e_stall) exp_stalls++;
      chk({vecs[i].name, ".stall_cycles"}, 32'(hz.stall_cycles), 32'(exp_stalls));
    end

    // Multiply followed by mflo; a div start during the wait must be ignored
    clear_in();
    hz.EX_md_start = 1'b1;
    tick();
    hz.EX_md_start   = 1'b0;
    hz.ID_reads_hilo = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        hz.EX_md_start  = 1'b1;
        hz.EX_md_is_div = 1'b1;
      end
      #1;
      chk($sformatf("mul.c%0d.md_busy", k), 32'(hz.md_busy), 32'd1);
      chk($sformatf("mul.c%0d.md_done", k), 32'(hz.md_done), 32'd0);
      chk_ctl($sformatf("mul.c%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      hz.EX_md_start  = 1'b0;
      hz.EX_md_is_div = 1'b0;
      exp_stalls++;
    end
    #1;
    chk("mul.c5.md_busy", 32'(hz.md_busy), 32'd0);
    chk("mul.c5.md_done", 32'(hz.md_done), 32'd1);
    chk_ctl("mul.c5", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mul.stall_cycles", 32'(hz.stall_cycles), 32'(exp_stalls));
    tick();
    chk("mul.c6.md_done", 32'(hz.md_done), 32'd0);
    chk("mul.c6.md_busy", 32'(hz.md_busy), 32'd0);

    // Divide with a second div waiting in ID
    clear_in();
    do_reset();
    hz.EX_md_start  = 1'b1;
    hz.EX_md_is_div = 1'b1;
    tick();
    clear_in();
    hz.ID_is_md = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      #1;
      chk($sformatf("div.c%0d.md_busy", k), 32'(hz.md_busy), 32'd1);
      chk($sformatf("div.c%0d.pc_write", k), 32'(hz.pc_write), 32'd0);
      tick();
    end
    #1;
    chk("div.end.md_busy", 32'(hz.md_busy), 32'd0);
    chk("div.end.md_done", 32'(hz.md_done), 32'd1);
    chk("div.end.pc_write", 32'(hz.pc_write), 32'd1);
    chk("div.stall_cycles", 32'(hz.stall_cycles), 32'd32);

    // Taken branch in the same cycle blocks the md start
    clear_in();
    tick();
    hz.EX_md_start     = 1'b1;
    hz.EX_branch_taken = 1'b1;
    #1;
    chk_ctl("br_md", 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    clear_in();
    chk("br_md.md_busy", 32'(hz.md_busy), 32'd0);

    // Reset at cycle 10 of a divide aborts it
    do_reset();
    hz.EX_md_start  = 1'b1;
    hz.EX_md_is_div = 1'b1;
    tick();
    clear_in();
    hz.ID_reads_hilo = 1'b1;
    repeat (9) tick();
    chk("rdiv.pre.stall_cycles", 32'(hz.stall_cycles), 32'd9);
    rst = 1'b1;
    #1;
    chk_ctl("rdiv.in_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    hz.ID_reads_hilo = 1'b0;
    chk("rdiv.md_busy", 32'(hz.md_busy), 32'd0);
    chk("rdiv.md_done", 32'(hz.md_done), 32'd0);
    chk("rdiv.stall_cycles", 32'(hz.stall_cycles), 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      if (hz.md_done) seen_done = 1'b1;
    end
    chk("rdiv.no_done", 32'(seen_done), 32'd0);

    // Stall counter saturation
    do_reset();
    hz.ID_EX_mem_read = 1'b1;
    hz.ID_EX_rt       = 5'd9;
    hz.IF_ID_rs       = 5'd9;
    repeat (65534) tick();
    chk("sat.fffe", 32'(hz.stall_cycles), 32'h0000_FFFE);
    tick();
    chk("sat.ffff", 32'(hz.stall_cycles), 32'h0000_FFFF);
    tick();
    chk("sat.hold", 32'(hz.stall_cycles), 32'h0000_FFFF);
    clear_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
